// File: rtl/soc_pkg.sv
// Shared SoC datapath types: default word width and elastic stage states.
package soc_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_reg_skid_stage.sv
// One elastic stage: main register plus skid slot, ready/valid decoded from state flops.
module skid_stage
  import soc_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             xfer_in;
  logic             xfer_out;

  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  // State and data registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state: skid absorbs one word when downstream stalls; flush empties, data kept.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (xfer_in) begin
          main_d  = in_data;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (xfer_in && xfer_out) begin
          main_d = in_data;
        end else if (xfer_in) begin
          skid_d  = in_data;
          state_d = S_FULL;
        end else if (xfer_out) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (xfer_out) begin
          main_d  = skid_q;
          state_d = S_BUSY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d = S_EMPTY;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Elastic pipeline register: STAGES chained skid stages plus an occupancy counter.
module pipe_reg
  import soc_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_WIDTH,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = $clog2(2 * STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  logic             stg_valid [STAGES+1];
  logic             stg_ready [STAGES+1];
  logic [WIDTH-1:0] stg_data  [STAGES+1];

  logic [CNT_W-1:0] count_q, count_d;
  logic             in_xfer;
  logic             out_xfer;

  assign stg_valid[0]      = in_valid;
  assign stg_data[0]       = in_data;
  assign stg_ready[STAGES] = out_ready;
  assign in_ready          = stg_ready[0];
  assign out_valid         = stg_valid[STAGES];
  assign out_data          = stg_data[STAGES];

  // Stage k sits between link k (upstream) and link k+1 (downstream).
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    skid_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (stg_valid[k]),
      .in_data  (stg_data[k]),
      .in_ready (stg_ready[k]),
      .out_valid(stg_valid[k+1]),
      .out_data (stg_data[k+1]),
      .out_ready(stg_ready[k+1])
    );
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign count    = count_q;

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Occupancy next-state: +1 on input, -1 on output, flush clears.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - CNT_W'(1);
    end
  end

endmodule
